sdp_ram_pipe: RTL and testbench



---
 rtl/sdp_ram_pipe_pkg.sv | 19 +
 rtl/sdp_ram_pipe_core.sv | 45 ++++
 rtl/sdp_ram_pipe.sv | 187 ++++++++++++++++++
 tb/tb_sdp_ram_pipe.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/sdp_ram_pipe_pkg.sv
// sdp_ram_pipe_pkg: shared definitions for the pipelined simple dual-port RAM.
//   byte_align()    rounds a data width up to a whole number of bytes
//   WM_*            encodings for the same-address collision behaviour
//   clr_state_e     states of the optional post-reset clear sequencer
package sdp_ram_pipe_pkg;

  localparam int WM_READ_FIRST  = 0;
  localparam int WM_WRITE_FIRST = 1;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } clr_state_e;

  function automatic int unsigned byte_align(input int unsigned w);
    return ((w + 32'd7) / 32'd8) * 32'd8;
  endfunction

endpackage

// File: rtl/sdp_ram_pipe_core.sv
// sdp_ram_pipe_core: inferred byte-write RAM with a registered, read-first read port.
//   clk_i            clock
//   rst_i            synchronous reset of the read output register only
//   wen_i/wbe_i      write enable / per-byte write strobes
//   waddr_i/wdata_i  write address / data (BW bits, byte aligned)
//   ren_i/raddr_i    read enable / read address
//   rdata_o          registered read data; holds while ren_i is low
module sdp_ram_pipe_core #(
  parameter string       MEM_TYPE = "auto",
  parameter int unsigned BW       = 128,
  parameter int unsigned AW       = 14
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            wen_i,
  input  logic [BW/8-1:0] wbe_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [BW-1:0]   wdata_i,
  input  logic            ren_i,
  input  logic [AW-1:0]   raddr_i,
  output logic [BW-1:0]   rdata_o
);

  localparam int unsigned NB = BW / 8;

  (* ram_style = MEM_TYPE *) logic [BW-1:0] mem_q [2**AW];
  logic [BW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (wen_i) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (wbe_i[i]) mem_q[waddr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
      end
    end
  end

  // Non-blocking read alongside the write gives the old word on a collision.
  always_ff @(posedge clk_i) begin
    if (rst_i)      rdata_q <= '0;
    else if (ren_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sdp_ram_pipe.sv
// sdp_ram_pipe: simple dual-port RAM (write port A, read port B, one clock) with
// configurable read latency, read-valid pipeline and same-address forwarding.
//   clk, reset        clock, synchronous active-high reset
//   ena, wea          write enable, per-byte write strobes (top bit = partial byte)
//   addra, dina       write address / data
//   enb, addrb        read request / address
//   doutb, rvalidb    read data (held between results), result valid strobe
//   init_done         memory usable; requests ignored while low
// Optional: define SDP_RAM_PIPE_INIT_CLEAR_EN to zero the whole array after reset.
module sdp_ram_pipe
  import sdp_ram_pipe_pkg::*;
#(
  parameter string       MEM_TYPE      = "auto",
  parameter int unsigned MEM_DATAWIDTH = 128,
  parameter int unsigned MEM_ADDRWIDTH = 14,
  parameter int unsigned READ_LATENCY  = 1,
  parameter string       WRITE_MODE    = "read_first"
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           ena,
  input  logic [(MEM_DATAWIDTH+7)/8-1:0] wea,
  input  logic [MEM_ADDRWIDTH-1:0]       addra,
  input  logic [MEM_DATAWIDTH-1:0]       dina,
  input  logic                           enb,
  input  logic [MEM_ADDRWIDTH-1:0]       addrb,
  output logic [MEM_DATAWIDTH-1:0]       doutb,
  output logic                           rvalidb,
  output logic                           init_done
);

  localparam int unsigned BW = byte_align(MEM_DATAWIDTH);
  localparam int unsigned NB = BW / 8;
  localparam int unsigned AW = MEM_ADDRWIDTH;
  localparam int          WM = (WRITE_MODE == "write_first") ? WM_WRITE_FIRST : WM_READ_FIRST;

  if (READ_LATENCY < 1 || READ_LATENCY > 3) begin : g_bad_latency
    $error("sdp_ram_pipe: READ_LATENCY must be in 1..3");
  end
  if (WRITE_MODE != "read_first" && WRITE_MODE != "write_first") begin : g_bad_mode
    $error("sdp_ram_pipe: WRITE_MODE must be \"read_first\" or \"write_first\"");
  end

  logic [BW-1:0] din_pad;
  logic          ready;
  logic          clearing;
  logic [AW-1:0] clr_addr;
  logic          rd_acc;
  logic          wr_acc;

  assign din_pad = BW'(dina);

`ifdef SDP_RAM_PIPE_INIT_CLEAR_EN
  clr_state_e    state_q;
  logic [AW-1:0] clr_addr_q;
  logic          init_done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_CLEAR;
      clr_addr_q  <= '0;
      init_done_q <= 1'b0;
    end else if (state_q == ST_CLEAR) begin
      clr_addr_q <= clr_addr_q + AW'(1);
      if (clr_addr_q == '1) begin
        state_q     <= ST_READY;
        init_done_q <= 1'b1;
      end
    end
  end

  assign clearing = (state_q == ST_CLEAR) && !reset;
  assign clr_addr = clr_addr_q;
  assign ready    = init_done_q;
`else
  assign clearing = 1'b0;
  assign clr_addr = '0;
  assign ready    = 1'b1;
`endif

  assign init_done = ready;
  assign rd_acc    = enb & ready & ~reset;
  assign wr_acc    = ena & ready & ~reset;

  // The clear sequencer owns the write port while it runs.
  logic          core_wen;
  logic [NB-1:0] core_wbe;
  logic [AW-1:0] core_waddr;
  logic [BW-1:0] core_wdata;

  always_comb begin
    core_wen   = wr_acc;
    core_wbe   = wea;
    core_waddr = addra;
    core_wdata = din_pad;
    if (clearing) begin
      core_wen   = 1'b1;
      core_wbe   = '1;
      core_waddr = clr_addr;
      core_wdata = '0;
    end
  end

  logic [BW-1:0] ram_rdata;

  sdp_ram_pipe_core #(
    .MEM_TYPE (MEM_TYPE),
    .BW       (BW),
    .AW       (AW)
  ) u_core (
    .clk_i   (clk),
    .rst_i   (reset),
    .wen_i   (core_wen),
    .wbe_i   (core_wbe),
    .waddr_i (core_waddr),
    .wdata_i (core_wdata),
    .ren_i   (rd_acc),
    .raddr_i (addrb),
    .rdata_o (ram_rdata)
  );

  // Collision bytes are captured beside the RAM output register and merged
  // after it, so stage 1 stays a single register level with a mux behind it.
  logic [NB-1:0] fwd_mask_d, fwd_mask_q;
  logic [BW-1:0] fwd_data_q;
  logic [BW-1:0] s1_data;

  always_comb begin
    fwd_mask_d = '0;
    if (WM == WM_WRITE_FIRST && wr_acc && (addra == addrb)) fwd_mask_d = wea;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fwd_mask_q <= '0;
      fwd_data_q <= '0;
    end else if (rd_acc) begin
      fwd_mask_q <= fwd_mask_d;
      fwd_data_q <= din_pad;
    end
  end

  always_comb begin
    s1_data = ram_rdata;
    for (int unsigned i = 0; i < NB; i++) begin
      if (fwd_mask_q[i]) s1_data[i*8 +: 8] = fwd_data_q[i*8 +: 8];
    end
  end

  // valid_q[s-1] marks a result sitting in stage s.
  logic [READ_LATENCY-1:0] valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= rd_acc;
      for (int unsigned i = 1; i < READ_LATENCY; i++) valid_q[i] <= valid_q[i-1];
    end
  end

  logic [BW-1:0] out_data;

  if (READ_LATENCY == 1) begin : g_lat1
    assign out_data = s1_data;
  end else begin : g_latn
    logic [BW-1:0] pipe_q [READ_LATENCY-1];

    // Each stage loads only when a valid result arrives, so doutb holds otherwise.
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int unsigned i = 0; i < READ_LATENCY - 1; i++) pipe_q[i] <= '0;
      end else begin
        if (valid_q[0]) pipe_q[0] <= s1_data;
        for (int unsigned i = 1; i < READ_LATENCY - 1; i++) begin
          if (valid_q[i]) pipe_q[i] <= pipe_q[i-1];
        end
      end
    end

    assign out_data = pipe_q[READ_LATENCY-2];
  end

  assign rvalidb = valid_q[READ_LATENCY-1];
  assign doutb   = out_data[MEM_DATAWIDTH-1:0];

endmodule

// File: tb/tb_sdp_ram_pipe.sv
// Bench for sdp_ram_pipe: three instances sharing one stimulus stream.
//   u_wf3: 32-bit, latency 3, write_first
//   u_wf2: 20-bit (partial top byte), latency 2, write_first
//   u_rf1: 32-bit, latency 1, read_first
module tb_sdp_ram_pipe;

`ifdef SDP_RAM_PIPE_INIT_CLEAR_EN
  localparam int CLR_CYCLES = 16;
`else
  localparam int CLR_CYCLES = 0;
`endif
  localparam int LAT [3] = '{3, 2, 1};

  logic        clk = 1'b0;
  logic        reset, ena, enb;
  logic [3:0]  wea, addra, addrb;
  logic [31:0] dina;
  logic [31:0] dout0, dout2;
  logic [19:0] dout1;
  logic [2:0]  rv, idn;
  logic [31:0] dout_w [3];

  always #5 clk = ~clk;

  sdp_ram_pipe #(.MEM_TYPE("auto"), .MEM_DATAWIDTH(32), .MEM_ADDRWIDTH(4),
                 .READ_LATENCY(3), .WRITE_MODE("write_first")) u_wf3 (
    .clk(clk), .reset(reset), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .enb(enb), .addrb(addrb), .doutb(dout0), .rvalidb(rv[0]), .init_done(idn[0]));

  sdp_ram_pipe #(.MEM_TYPE("distributed"), .MEM_DATAWIDTH(20), .MEM_ADDRWIDTH(4),
                 .READ_LATENCY(2), .WRITE_MODE("write_first")) u_wf2 (
    .clk(clk), .reset(reset), .ena(ena), .wea(wea[2:0]), .addra(addra), .dina(dina[19:0]),
    .enb(enb), .addrb(addrb), .doutb(dout1), .rvalidb(rv[1]), .init_done(idn[1]));

  sdp_ram_pipe #(.MEM_TYPE("block"), .MEM_DATAWIDTH(32), .MEM_ADDRWIDTH(4),
                 .READ_LATENCY(1), .WRITE_MODE("read_first")) u_rf1 (
    .clk(clk), .reset(reset), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .enb(enb), .addrb(addrb), .doutb(dout2), .rvalidb(rv[2]), .init_done(idn[2]));

  assign dout_w[0] = dout0;
  assign dout_w[1] = {12'h000, dout1};
  assign dout_w[2] = dout2;

  typedef struct {
    int          inst;
    int          due;
    logic [31:0] data;
  } sb_t;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] din;
    logic [3:0]  wea;
    logic [31:0] e0, e1, e2;
  } vec_t;

  sb_t         sbq [$];
  vec_t        vt [8];
  logic [31:0] exp_rd [3];
  logic [31:0] last_d [3];
  int          edge_n = 0;
  int          clr_left = 0;
  int          n_vec = 0;
  int          n_err = 0;
  bit          mon_en = 1'b0;

  // Acceptance model: a read at edge e emerges after edge e+LAT-1.
  always @(posedge clk) begin
    edge_n++;
    if (reset) begin
      sbq.delete();
      for (int k = 0; k < 3; k++) last_d[k] = '0;
      clr_left = CLR_CYCLES;
    end else begin
      if (enb && clr_left == 0) begin
        for (int k = 0; k < 3; k++) sbq.push_back('{k, edge_n + LAT[k] - 1, exp_rd[k]});
      end
      if (clr_left > 0) clr_left--;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      for (int k = 0; k < 3; k++) begin
        int idx;
        idx = -1;
        foreach (sbq[j]) if (idx < 0 && sbq[j].inst == k && sbq[j].due == edge_n) idx = j;
        n_vec++;
        if (idx >= 0) begin
          if (rv[k] !== 1'b1 || dout_w[k] !== sbq[idx].data) begin
            n_err++;
            $display("FAIL rd%0d edge %0d: rvalidb=%b doutb=%h, want rvalidb=1 doutb=%h",
                     k, edge_n, rv[k], dout_w[k], sbq[idx].data);
          end
          last_d[k] = sbq[idx].data;
          sbq.delete(idx);
        end else if (rv[k] !== 1'b0 || dout_w[k] !== last_d[k]) begin
          n_err++;
          $display("FAIL idle%0d edge %0d: rvalidb=%b doutb=%h, want rvalidb=0 doutb=%h",
                   k, edge_n, rv[k], dout_w[k], last_d[k]);
        end
        n_vec++;
        if (idn[k] !== (clr_left == 0)) begin
          n_err++;
          $display("FAIL init_done%0d edge %0d: got %b, want %b", k, edge_n, idn[k], clr_left == 0);
        end
      end
    end
  end

  task automatic step(input logic r, input logic ea, input logic [3:0] we, input logic [3:0] aa,
                      input logic [31:0] da, input logic eb, input logic [3:0] ab,
                      input logic [31:0] x0, input logic [31:0] x1, input logic [31:0] x2);
    reset = r; ena = ea; wea = we; addra = aa; dina = da;
    enb = eb; addrb = ab;
    exp_rd[0] = x0; exp_rd[1] = x1; exp_rd[2] = x2;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] we);
    step(1'b0, 1'b1, we, a, d, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] x0, input logic [31:0] x1,
                    input logic [31:0] x2);
    step(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b1, a, x0, x1, x2);
  endtask

  initial begin
    // Each row writes, then reads back; expectations are per instance (u_wf2 keeps 20 bits, 3 strobes).
    vt[0] = '{4'd5, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF, 32'h000DBEEF, 32'hDEADBEEF};
    vt[1] = '{4'd3, 32'h00000000, 4'hF, 32'h00000000, 32'h00000000, 32'h00000000};
    vt[2] = '{4'd3, 32'hFFFFFFFF, 4'h4, 32'h00FF0000, 32'h000F0000, 32'h00FF0000};
    vt[3] = '{4'd3, 32'h12345678, 4'h1, 32'h00FF0078, 32'h000F0078, 32'h00FF0078};
    vt[4] = '{4'd3, 32'hA5A5A5A5, 4'h0, 32'h00FF0078, 32'h000F0078, 32'h00FF0078};
    vt[5] = '{4'd7, 32'h11223344, 4'hF, 32'h11223344, 32'h00023344, 32'h11223344};
    vt[6] = '{4'd5, 32'h01020304, 4'h8, 32'h01ADBEEF, 32'h000DBEEF, 32'h01ADBEEF};
    vt[7] = '{4'd5, 32'h00000000, 4'h2, 32'h01AD00EF, 32'h000D00EF, 32'h01AD00EF};

    reset = 1'b1; ena = 1'b0; enb = 1'b0; wea = '0; addra = '0; addrb = '0; dina = '0;
    for (int k = 0; k < 3; k++) begin exp_rd[k] = '0; last_d[k] = '0; end
    step(1'b1, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
    mon_en = 1'b1;
    step(1'b1, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);

`ifdef SDP_RAM_PIPE_INIT_CLEAR_EN
    // Requests during clear are ignored; reset at cycle 8 restarts the sweep.
    for (int i = 0; i < 7; i++)
      step(1'b0, 1'b1, 4'hF, 4'(i), 32'hFFFFFFFF, 1'b1, 4'(i), 32'h0, 32'h0, 32'h0);
    step(1'b1, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
    for (int i = 0; i < 16; i++)
      step(1'b0, 1'b1, 4'hF, 4'h0, 32'hFFFFFFFF, 1'b1, 4'(i), 32'h0, 32'h0, 32'h0);
    for (int i = 0; i < 16; i++) rd(4'(i), 32'h0, 32'h0, 32'h0);
    idle(4);
`endif

    for (int i = 0; i < 8; i++) begin
      wr(vt[i].addr, vt[i].din, vt[i].wea);
      rd(vt[i].addr, vt[i].e0, vt[i].e1, vt[i].e2);
      idle(1);
    end
    idle(3);

    // Same-address collision on addr 7 (holds 11223344).
    step(1'b0, 1'b1, 4'b0101, 4'd7, 32'hAABBCCDD, 1'b1, 4'd7,
         32'h11BB33DD, 32'h000B33DD, 32'h11223344);
    rd(4'd7, 32'h11BB33DD, 32'h000B33DD, 32'h11BB33DD);

    // Write behind an in-flight read, with an unrelated read in the same cycle.
    rd(4'd5, 32'h01AD00EF, 32'h000D00EF, 32'h01AD00EF);
    step(1'b0, 1'b1, 4'hF, 4'd5, 32'hFFFFFFFF, 1'b1, 4'd7,
         32'h11BB33DD, 32'h000B33DD, 32'h11BB33DD);
    rd(4'd5, 32'hFFFFFFFF, 32'h000FFFFF, 32'hFFFFFFFF);
    idle(4);

    // Back-to-back burst.
    for (int i = 0; i < 8; i++) wr(4'(8 + i), 32'hA0B0C000 + 32'(i) * 32'h111, 4'hF);
    for (int i = 0; i < 8; i++) begin
      logic [31:0] d;
      d = 32'hA0B0C000 + 32'(i) * 32'h111;
      rd(4'(8 + i), d, d & 32'h000FFFFF, d);
    end
    idle(5);

    // Reset mid-stream discards in-flight reads.
    for (int i = 0; i < 4; i++) begin
      logic [31:0] d;
      d = 32'hA0B0C000 + 32'(i) * 32'h111;
      rd(4'(8 + i), d, d & 32'h000FFFFF, d);
    end
    step(1'b1, 1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd9, 32'h0, 32'h0, 32'h0);
    idle(17);
`ifdef SDP_RAM_PIPE_INIT_CLEAR_EN
    rd(4'd7, 32'h0, 32'h0, 32'h0);
`else
    rd(4'd7, 32'h11BB33DD, 32'h000B33DD, 32'h11BB33DD);
`endif
    idle(4);

    n_vec++;
    if (sbq.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d results never emerged, want 0", sbq.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
